// File: rtl/if_prefetch.sv
// ---------------------------------------------------------------------------
// if_prefetch
//
// Instruction-fetch stage with a DEPTH-entry prefetch queue. The stage keeps
// requesting sequential instructions from the memory controller while the
// decode stage is stalled. It presents the oldest fetched instruction
// (the head entry) to the IF/ID register.
//
// A jump flushes the queue. Any fetch that is still in flight at that moment
// is completed on the bus and its data thrown away.
//
// Parameters
//   ADDR_W    PC / fetch address width
//   INST_W    instruction width; the sequential PC step is INST_W/8 bytes
//   DEPTH     queue entries (power of two, >= 2)
//   RESET_PC  first fetch address after reset
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   stall_i      decode stall; the head entry is held
//   jump_i       one-cycle redirect strobe (priority over push/pop)
//   jump_addr_i  redirect target
//   mem_req_o    fetch request to the memory controller
//   mem_addr_o   fetch address, stable while mem_req_o is high
//   mem_done_i   one-cycle completion strobe, data valid with it
//   mem_inst_i   fetched instruction
//   pc_o         PC of the head entry (0 when the queue is empty)
//   inst_o       head instruction (0 when the queue is empty)
//   valid_o      head entry valid
//   stall_req_o  fetch-side stall request (queue empty)
// ---------------------------------------------------------------------------
module if_prefetch #(
  parameter int unsigned           ADDR_W   = 32,
  parameter int unsigned           INST_W   = 32,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              jump_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_done_i,
  input  logic [INST_W-1:0] mem_inst_i,
  output logic [ADDR_W-1:0] pc_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output logic              stall_req_o
);

  localparam int unsigned         PTR_W   = $clog2(DEPTH);
  localparam int unsigned         CNT_W   = PTR_W + 1;
  localparam logic [ADDR_W-1:0]   PC_STEP = ADDR_W'(INST_W / 8);
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DROP
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]   drop_addr_q, drop_addr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [ADDR_W-1:0]   pc_queue_q   [DEPTH];
  logic [ADDR_W-1:0]   pc_queue_d   [DEPTH];
  logic [INST_W-1:0]   inst_queue_q [DEPTH];
  logic [INST_W-1:0]   inst_queue_d [DEPTH];

  logic                push;
  logic                pop;

  // Head-of-queue view. Outputs are forced to zero when the queue is empty,
  // so stale storage contents never leak to IF/ID.
  always_comb begin
    valid_o     = (count_q != '0);
    stall_req_o = (count_q == '0);
    pc_o        = '0;
    inst_o      = '0;
    if (count_q != '0) begin
      pc_o   = pc_queue_q[rd_ptr_q];
      inst_o = inst_queue_q[rd_ptr_q];
    end
  end

  // Memory port and push/pop qualification. A push only happens on a
  // completion in REQ that is not cancelled by a simultaneous jump. Outside
  // REQ/DROP the address is parked at zero.
  always_comb begin
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
    push       = 1'b0;
    pop        = (count_q != '0) && !stall_i && !jump_i;
    case (state_q)
      ST_REQ: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fetch_pc_q;
        push       = mem_done_i && !jump_i;
      end
      ST_DROP: begin
        mem_req_o  = 1'b1;
        mem_addr_o = drop_addr_q;
      end
      default: begin
        mem_req_o  = 1'b0;
        mem_addr_o = '0;
      end
    endcase
  end

  // Queue bookkeeping and fetch PC. A jump clears the queue and redirects
  // fetch_pc regardless of what else happens in the same cycle.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pc_queue_d   = pc_queue_q;
    inst_queue_d = inst_queue_q;

    if (jump_i) begin
      fetch_pc_d = jump_addr_i;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        pc_queue_d[wr_ptr_q]   = fetch_pc_q;
        inst_queue_d[wr_ptr_q] = mem_inst_i;
        wr_ptr_d               = wr_ptr_q + 1'b1;
        fetch_pc_d             = fetch_pc_q + PC_STEP;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Fetch FSM. REQ is left as soon as the queue would become full, which
  // is why a push and a pop can never meet on a full queue. DROP waits for
  // the abandoned request to complete before issuing the new one. A jump
  // that lands on the very cycle the dropped request completes still goes
  // to REQ, because no further completion for the old address will come.
  always_comb begin
    state_d     = state_q;
    drop_addr_d = drop_addr_q;
    case (state_q)
      ST_IDLE: begin
        if (jump_i || (count_d < DEPTH_C)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (jump_i) begin
          if (mem_done_i) begin
            state_d = ST_REQ;
          end else begin
            state_d     = ST_DROP;
            drop_addr_d = fetch_pc_q;
          end
        end else if (mem_done_i) begin
          state_d = (count_d < DEPTH_C) ? ST_REQ : ST_IDLE;
        end
      end
      ST_DROP: begin
        if (mem_done_i) begin
          state_d = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        pc_queue_q[i]   <= '0;
        inst_queue_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_addr_q  <= drop_addr_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pc_queue_q   <= pc_queue_d;
      inst_queue_q <= inst_queue_d;
    end
  end

endmodule

// File: doc/if_prefetch.md
# if_prefetch

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue. It replaces the single-instruction, combinational IF stage. It keeps fetching sequential addresses from the memory controller while ID is stalled, and presents the oldest fetched instruction to IF/ID. On a jump it flushes the queue and discards any in-flight fetch. It sits between the PC/memory-controller port and the IF/ID pipeline register.

## Interface
Parameters:
- ADDR_W, 32, PC/address width
- INST_W, 32, instruction width; PC step is INST_W/8
- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- stall_i  in  1  downstream stall; head entry is held
- jump_i  in  1  one-cycle redirect strobe
- jump_addr_i  in  ADDR_W  redirect target
- mem_req_o  out  1  fetch request to memory controller
- mem_addr_o  out  ADDR_W  fetch address; stable while mem_req_o=1
- mem_done_i  in  1  one-cycle completion strobe; data valid with it
- mem_inst_i  in  INST_W  fetched instruction
- pc_o  out  ADDR_W  PC of head entry
- inst_o  out  INST_W  head instruction
- valid_o  out  1  head entry valid
- stall_req_o  out  1  fetch-side stall request to pipeline control

## Operation
State registers:
- fetch_pc (ADDR_W)
- circular queue of {pc, inst} with rd_ptr/wr_ptr (log2 DEPTH bits, wrap at DEPTH)
- count (log2 DEPTH + 1 bits)
- FSM

Output path:
- valid_o = (count≠0). pc_o/inst_o show the head entry when valid, otherwise 0.
- stall_req_o = !valid_o.
- pop = valid_o && !stall_i && !jump_i.

FSM states IDLE, REQ, DROP:
- **IDLE**: mem_req_o=0. Go to REQ when count_next<DEPTH.
- **REQ**: mem_req_o=1, mem_addr_o=fetch_pc.
  - On mem_done_i without jump: push {fetch_pc, mem_inst_i}, fetch_pc += INST_W/8. Stay in REQ if count_next<DEPTH, else go to IDLE.
  - Without mem_done_i: hold the request.
- **DROP**: mem_req_o=1, mem_addr_o = old (pre-jump) address, latched. On mem_done_i: discard data and go to REQ.

Counting:
- count_next = count + push − pop.
- A push and a pop in the same cycle on a full queue is impossible, because REQ is left before the queue is full.

jump_i (priority over push and pop):
- count, rd_ptr and wr_ptr are cleared; fetch_pc ← jump_addr_i.
- In REQ without mem_done_i: go to DROP, keeping the old address on mem_addr_o.
- In REQ with mem_done_i in the same cycle: data is discarded; go to REQ.
- In IDLE: go to REQ.
- In DROP: stay in DROP; the new target replaces fetch_pc.

Other rules:
- mem_done_i outside REQ/DROP is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.

## Timing
Reset values (asynchronous, immediate on rst): state IDLE, fetch_pc=RESET_PC, count=0, pointers=0, mem_req_o=0, mem_addr_o=0, valid_o=0, pc_o=0, inst_o=0. stall_req_o=1 (queue empty).

Latency and throughput:
- First rising edge after rst falls: IDLE→REQ. mem_req_o=1 in cycle 1.
- mem_done_i may arrive in the same cycle as the request (zero-wait memory); the push happens at that edge.
- A pushed entry is visible on valid_o/pc_o/inst_o the cycle after mem_done_i. There is no bypass.
- Sustained throughput with zero-wait memory and no stall is 1 instruction/cycle.
- Jump: the queue is empty the next cycle. The first target instruction appears 1 cycle after its mem_done_i. In DROP this is one extra memory round-trip later.
- Pop takes effect at the clock edge; the next head is shown the following cycle.

Reset mid-operation: all state returns to reset values immediately. An in-flight memory response arriving after reset release is ignored, because the FSM is in IDLE.

## Test plan
- **Reset**: assert rst mid-fetch with count=3 -> all outputs at reset values in the same cycle. After release: mem_req_o=1, mem_addr_o=RESET_PC.
- **Fill under stall**: DEPTH=4, zero-wait memory, stall_i=1 -> 4 pushes (PCs 0x0, 0x4, 0x8, 0xC), then mem_req_o=0 and valid_o=1 with pc_o=0x0. Release stall -> pops in order, fetch resumes at 0x10.
- **Streaming**: zero-wait memory, stall_i=0 -> valid_o continuously 1 from cycle 2; pc_o steps 0x0, 0x4, 0x8, … once per cycle.
- **Jump with outstanding request**: 3-cycle memory latency, jump_i to 0x100 one cycle into a request at 0x8 -> FSM goes to DROP, mem_addr_o stays 0x8, the returned data is discarded. The next request is to 0x100, and pc_o=0x100 appears 1 cycle after its mem_done_i.
- **Jump coincident with mem_done_i**: the data is not pushed, the queue becomes empty, and mem_addr_o=jump_addr_i the next cycle.
- **Wrap**: run 2×DEPTH+1 pushes and pops with intermittent stall_i -> PC order is preserved across pointer wrap-around, and count never exceeds DEPTH.
